bcd_mult_sequencer: RTL and testbench

//  Multi-cycle controller/datapath sequencer for a 1-digit x 1-digit BCD multiply (Z = X*Y, 2-digit BCD result).

---
 rtl/bcd_mult_sequencer_pkg.sv | 20 ++
 rtl/bcd_mult_sequencer_if.sv | 25 ++
 rtl/bcd_mult_sequencer_dd_step.sv | 21 ++
 rtl/bcd_mult_sequencer.sv | 109 ++++++++++
 tb/tb_bcd_mult_sequencer.sv | 230 +++++++++++++++++++++++
 5 files changed

// File: rtl/bcd_mult_sequencer_pkg.sv
// Shared types and constants for the sequential BCD digit multiplier.
// Holds the FSM encoding and step counts used by the top and the bench.
package bcd_mult_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MUL  = 2'd1,
        ST_CONV = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    localparam int         MUL_STEPS  = 4;
    localparam int         CONV_STEPS = 7;
    localparam logic [3:0] BCD_MAX    = 4'd9;

    function automatic logic is_bcd_digit(input logic [3:0] d);
        return d <= BCD_MAX;
    endfunction

endpackage

// File: rtl/bcd_mult_sequencer_if.sv
// Operand/result handshake bundle between source, multiplier and sink.
// Bit 0 of x, y and z is the most significant bit.
interface bcd_mult_sequencer_if;

    logic       in_valid;
    logic       in_ready;
    logic [0:3] x;
    logic [0:3] y;
    logic       out_valid;
    logic       out_ready;
    logic [0:7] z;
    logic       err;
    logic       busy;

    modport master (
        output in_valid, x, y, out_ready,
        input  in_ready, out_valid, z, err, busy
    );

    modport slave (
        input  in_valid, x, y, out_ready,
        output in_ready, out_valid, z, err, busy
    );

endinterface

// File: rtl/bcd_mult_sequencer_dd_step.sv
// One double-dabble iteration on {tens, units, binary}: add 3 to BCD nibbles >= 5, then shift left.
// Purely combinational, no handshake.
module bcd_dd_step (
    input  logic [14:0] sr_in,
    output logic [14:0] sr_out
);

    logic [14:0] adj;

    always_comb begin
        adj = sr_in;
        if (sr_in[14:11] >= 4'd5) begin
            adj[14:11] = sr_in[14:11] + 4'd3;
        end
        if (sr_in[10:7] >= 4'd5) begin
            adj[10:7] = sr_in[10:7] + 4'd3;
        end
        sr_out = {adj[13:0], 1'b0};
    end

endmodule

// File: rtl/bcd_mult_sequencer.sv
// Sequential 1x1 digit BCD multiplier: 4 shift-add steps then 7 double-dabble steps.
// Latency 11 cycles accept-to-out_valid (1 cycle on the fast error path); one op in flight.
// Backpressure: in_ready only in IDLE; result held in DONE until out_ready.
module bcd_mult_sequencer
    import bcd_mult_pkg::*;
#(
    parameter logic [7:0] ERR_RESULT = 8'h00,
    parameter bit         ERR_FAST   = 1'b1
) (
    input  logic                 clk,
    input  logic                 rst,
    bcd_mult_sequencer_if.slave  bus
);

    localparam logic [2:0] MUL_LAST  = 3'(MUL_STEPS - 1);
    localparam logic [2:0] CONV_LAST = 3'(CONV_STEPS - 1);

    state_t      state_q;
    state_t      state_d;
    logic [2:0]  cnt_q;
    logic [3:0]  x_q;
    logic [3:0]  y_q;
    logic [14:0] sr_q;
    logic        err_op_q;
    logic [7:0]  z_q;
    logic        err_q;

    logic        op_err;
    logic        fast_err;
    logic [6:0]  addend;
    logic [14:0] dd_out;

    assign op_err   = !is_bcd_digit(bus.x) || !is_bcd_digit(bus.y);
    assign fast_err = err_op_q && ERR_FAST;
    assign addend   = y_q[0] ? (7'({3'b000, x_q}) << cnt_q) : 7'd0;

    bcd_dd_step u_dd_step (
        .sr_in  (sr_q),
        .sr_out (dd_out)
    );

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (bus.in_valid)            state_d = ST_MUL;
            ST_MUL: begin
                if (fast_err)                     state_d = ST_DONE;
                else if (cnt_q == MUL_LAST)       state_d = ST_CONV;
            end
            ST_CONV: if (cnt_q == CONV_LAST)      state_d = ST_DONE;
            ST_DONE: if (bus.out_ready)           state_d = ST_IDLE;
            default:                              state_d = ST_IDLE;
        endcase
    end

    // The low 7 bits of sr_q serve as the product accumulator during MUL,
    // so CONV starts on the finished product with no extra load cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            cnt_q    <= 3'd0;
            x_q      <= 4'd0;
            y_q      <= 4'd0;
            sr_q     <= 15'd0;
            err_op_q <= 1'b0;
            z_q      <= 8'h00;
            err_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            case (state_q)
                ST_IDLE: begin
                    if (bus.in_valid) begin
                        x_q      <= bus.x;
                        y_q      <= bus.y;
                        err_op_q <= op_err;
                        sr_q     <= 15'd0;
                        cnt_q    <= 3'd0;
                    end
                end
                ST_MUL: begin
                    if (fast_err) begin
                        z_q   <= ERR_RESULT;
                        err_q <= 1'b1;
                    end else begin
                        sr_q[6:0] <= sr_q[6:0] + addend;
                        y_q       <= y_q >> 1;
                        cnt_q     <= (cnt_q == MUL_LAST) ? 3'd0 : cnt_q + 3'd1;
                    end
                end
                ST_CONV: begin
                    sr_q  <= dd_out;
                    cnt_q <= (cnt_q == CONV_LAST) ? 3'd0 : cnt_q + 3'd1;
                    if (cnt_q == CONV_LAST) begin
                        z_q   <= err_op_q ? ERR_RESULT : dd_out[14:7];
                        err_q <= err_op_q;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.in_ready  = (state_q == ST_IDLE);
    assign bus.out_valid = (state_q == ST_DONE);
    assign bus.busy      = (state_q != ST_IDLE);
    assign bus.z         = z_q;
    assign bus.err       = err_q;

endmodule

// File: tb/tb_bcd_mult_sequencer.sv
// Bench for bcd_mult_sequencer: two instances (fast and full-length error path)
// checked against a plain-arithmetic reference of the decimal product.
module tb_bcd_mult_sequencer;

    localparam logic [7:0] ERR_Z = 8'h00;

    logic clk = 1'b0;
    logic rst;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    bcd_mult_sequencer_if bus_f ();
    bcd_mult_sequencer_if bus_s ();

    bcd_mult_sequencer #(.ERR_RESULT(ERR_Z), .ERR_FAST(1'b1)) dut_fast (
        .clk (clk), .rst (rst), .bus (bus_f.slave)
    );
    bcd_mult_sequencer #(.ERR_RESULT(ERR_Z), .ERR_FAST(1'b0)) dut_slow (
        .clk (clk), .rst (rst), .bus (bus_s.slave)
    );

    function automatic logic [7:0] ref_z(input int a, input int b);
        int p;
        if (a > 9 || b > 9) return ERR_Z;
        p = a * b;
        return {4'(p / 10), 4'(p % 10)};
    endfunction

    function automatic int ref_lat(input int a, input int b, input bit fast);
        return ((a > 9 || b > 9) && fast) ? 1 : 11;
    endfunction

    function automatic logic get_ov(input bit slow);   return slow ? bus_s.out_valid : bus_f.out_valid; endfunction
    function automatic logic get_ir(input bit slow);   return slow ? bus_s.in_ready  : bus_f.in_ready;  endfunction
    function automatic logic get_busy(input bit slow); return slow ? bus_s.busy      : bus_f.busy;      endfunction
    function automatic logic get_err(input bit slow);  return slow ? bus_s.err       : bus_f.err;       endfunction
    function automatic logic [7:0] get_z(input bit slow); return slow ? bus_s.z : bus_f.z; endfunction

    task automatic drive(input bit slow, input logic v, input logic [3:0] a, input logic [3:0] b, input logic r);
        if (slow) begin
            bus_s.in_valid = v; bus_s.x = a; bus_s.y = b; bus_s.out_ready = r;
        end else begin
            bus_f.in_valid = v; bus_f.x = a; bus_f.y = b; bus_f.out_ready = r;
        end
    endtask

    // Presents one operand pair at a negedge, waits for out_valid and, unless
    // keep is set, hands the result off; lat counts edges after the accept edge.
    task automatic run_op(input bit slow, input logic [3:0] a, input logic [3:0] b,
                          input bit noise, input bit keep,
                          output int lat, output logic [7:0] zo, output logic eo);
        int n;
        checks++;
        if (get_ir(slow) !== 1'b1) begin
            errors++;
            $display("FAIL accept_ready in_ready=%b want 1", get_ir(slow));
        end
        drive(slow, 1'b1, a, b, !keep);
        @(negedge clk);
        drive(slow, 1'b0, 4'd0, 4'd0, !keep);
        n = 0;
        while (get_ov(slow) !== 1'b1 && n < 40) begin
            checks++;
            if (get_busy(slow) !== 1'b1 || get_ir(slow) !== 1'b0) begin
                errors++;
                $display("FAIL busy_window busy=%b in_ready=%b want 1/0", get_busy(slow), get_ir(slow));
            end
            if (noise) drive(slow, 1'($urandom), 4'($urandom), 4'($urandom), !keep);
            @(negedge clk);
            n++;
        end
        drive(slow, 1'b0, 4'd0, 4'd0, !keep);
        if (n >= 40) begin
            errors++;
            $display("FAIL timeout out_valid never rose within %0d cycles", n);
        end
        lat = n;
        zo  = get_z(slow);
        eo  = get_err(slow);
        if (!keep) @(negedge clk);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        drive(1'b0, 1'b0, 4'd0, 4'd0, 1'b0);
        drive(1'b1, 1'b0, 4'd0, 4'd0, 1'b0);
        repeat (2) @(negedge clk);
        checks++; if (bus_f.in_ready  !== 1'b1)  begin errors++; $display("FAIL rst_in_ready got=%b want 1", bus_f.in_ready); end
        checks++; if (bus_f.out_valid !== 1'b0)  begin errors++; $display("FAIL rst_out_valid got=%b want 0", bus_f.out_valid); end
        checks++; if (bus_f.busy      !== 1'b0)  begin errors++; $display("FAIL rst_busy got=%b want 0", bus_f.busy); end
        checks++; if (bus_f.err       !== 1'b0)  begin errors++; $display("FAIL rst_err got=%b want 0", bus_f.err); end
        checks++; if (bus_f.z         !== 8'h00) begin errors++; $display("FAIL rst_z got=%h want 00", bus_f.z); end
        checks++; if (bus_s.out_valid !== 1'b0 || bus_s.in_ready !== 1'b1) begin
            errors++; $display("FAIL rst_slow ov=%b ir=%b want 0/1", bus_s.out_valid, bus_s.in_ready);
        end
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_basic();
        int lat; logic [7:0] zo; logic eo;
        run_op(1'b0, 4'd9, 4'd9, 1'b0, 1'b0, lat, zo, eo);
        checks++; if (lat !== 11)    begin errors++; $display("FAIL basic_lat got=%0d want 11", lat); end
        checks++; if (zo  !== 8'h81) begin errors++; $display("FAIL basic_z got=%h want 81", zo); end
        checks++; if (eo  !== 1'b0)  begin errors++; $display("FAIL basic_err got=%b want 0", eo); end
        checks++; if (bus_f.in_ready !== 1'b1 || bus_f.out_valid !== 1'b0) begin
            errors++; $display("FAIL basic_turnaround ir=%b ov=%b want 1/0", bus_f.in_ready, bus_f.out_valid);
        end
    endtask

    task automatic test_exhaustive();
        int lat; logic [7:0] zo; logic eo;
        for (int a = 0; a < 10; a++) begin
            for (int b = 0; b < 10; b++) begin
                run_op(1'b0, 4'(a), 4'(b), 1'b0, 1'b0, lat, zo, eo);
                checks++; if (zo !== ref_z(a, b)) begin errors++; $display("FAIL exh_z %0d*%0d got=%h want=%h", a, b, zo, ref_z(a, b)); end
                checks++; if (eo !== 1'b0 || lat !== 11) begin errors++; $display("FAIL exh_err_lat %0d*%0d err=%b lat=%0d want 0/11", a, b, eo, lat); end
            end
        end
    endtask

    task automatic test_random();
        int lat; logic [7:0] zo; logic eo; int a; int b; int wait_n; bit keep;
        for (int i = 0; i < 40; i++) begin
            a = $urandom_range(0, 15);
            b = $urandom_range(0, 15);
            keep = 1'($urandom);
            run_op(1'b0, 4'(a), 4'(b), 1'b0, keep, lat, zo, eo);
            checks++; if (zo !== ref_z(a, b)) begin errors++; $display("FAIL rnd_z %0d*%0d got=%h want=%h", a, b, zo, ref_z(a, b)); end
            checks++; if (eo !== (a > 9 || b > 9)) begin errors++; $display("FAIL rnd_err %0d*%0d got=%b", a, b, eo); end
            checks++; if (lat !== ref_lat(a, b, 1'b1)) begin errors++; $display("FAIL rnd_lat %0d*%0d got=%0d want=%0d", a, b, lat, ref_lat(a, b, 1'b1)); end
            if (keep) begin
                wait_n = $urandom_range(0, 3);
                repeat (wait_n) @(negedge clk);
                drive(1'b0, 1'b0, 4'd0, 4'd0, 1'b1);
                @(negedge clk);
            end
        end
    endtask

    task automatic test_hold();
        int lat; logic [7:0] zo; logic eo;
        run_op(1'b0, 4'd3, 4'd4, 1'b0, 1'b1, lat, zo, eo);
        checks++; if (zo !== 8'h12 || lat !== 11) begin errors++; $display("FAIL hold_first z=%h lat=%0d want 12/11", zo, lat); end
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            checks++;
            if (bus_f.out_valid !== 1'b1 || bus_f.z !== 8'h12 || bus_f.in_ready !== 1'b0) begin
                errors++; $display("FAIL hold_stable cyc=%0d ov=%b z=%h ir=%b want 1/12/0", i, bus_f.out_valid, bus_f.z, bus_f.in_ready);
            end
        end
        drive(1'b0, 1'b0, 4'd0, 4'd0, 1'b1);
        @(negedge clk);
        checks++; if (bus_f.in_ready !== 1'b1 || bus_f.out_valid !== 1'b0) begin
            errors++; $display("FAIL hold_release ir=%b ov=%b want 1/0", bus_f.in_ready, bus_f.out_valid);
        end
    endtask

    task automatic test_err_paths();
        int lat; logic [7:0] zo; logic eo;
        run_op(1'b0, 4'hB, 4'd2, 1'b0, 1'b0, lat, zo, eo);
        checks++; if (lat !== 1)                  begin errors++; $display("FAIL errfast_lat got=%0d want 1", lat); end
        checks++; if (eo !== 1'b1 || zo !== ERR_Z) begin errors++; $display("FAIL errfast_out err=%b z=%h want 1/%h", eo, zo, ERR_Z); end
        run_op(1'b1, 4'd7, 4'd6, 1'b0, 1'b0, lat, zo, eo);
        checks++; if (zo !== 8'h42 || eo !== 1'b0) begin errors++; $display("FAIL slow_valid z=%h err=%b want 42/0", zo, eo); end
        run_op(1'b1, 4'hB, 4'd2, 1'b0, 1'b0, lat, zo, eo);
        checks++; if (lat !== 11)                 begin errors++; $display("FAIL errslow_lat got=%0d want 11", lat); end
        checks++; if (eo !== 1'b1 || zo !== ERR_Z) begin errors++; $display("FAIL errslow_out err=%b z=%h want 1/%h", eo, zo, ERR_Z); end
    endtask

    task automatic test_reset_mid();
        int lat; logic [7:0] zo; logic eo;
        run_op(1'b0, 4'd9, 4'd8, 1'b0, 1'b0, lat, zo, eo);
        checks++; if (zo !== 8'h72) begin errors++; $display("FAIL pre_reset_z got=%h want 72", zo); end
        drive(1'b0, 1'b1, 4'd6, 4'd7, 1'b1);
        @(negedge clk);
        drive(1'b0, 1'b0, 4'd0, 4'd0, 1'b1);
        repeat (6) @(negedge clk);
        checks++; if (bus_f.busy !== 1'b1 || bus_f.out_valid !== 1'b0) begin
            errors++; $display("FAIL midconv_busy busy=%b ov=%b want 1/0", bus_f.busy, bus_f.out_valid);
        end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        checks++; if (bus_f.in_ready !== 1'b1 || bus_f.out_valid !== 1'b0 || bus_f.busy !== 1'b0) begin
            errors++; $display("FAIL midrst_ctrl ir=%b ov=%b busy=%b want 1/0/0", bus_f.in_ready, bus_f.out_valid, bus_f.busy);
        end
        checks++; if (bus_f.z !== 8'h00 || bus_f.err !== 1'b0) begin
            errors++; $display("FAIL midrst_data z=%h err=%b want 00/0", bus_f.z, bus_f.err);
        end
        run_op(1'b0, 4'd5, 4'd5, 1'b0, 1'b0, lat, zo, eo);
        checks++; if (zo !== 8'h25 || lat !== 11) begin errors++; $display("FAIL post_rst z=%h lat=%0d want 25/11", zo, lat); end
    endtask

    task automatic test_ignore_inputs();
        int lat; logic [7:0] zo; logic eo; int a; int b;
        run_op(1'b0, 4'd8, 4'd7, 1'b1, 1'b0, lat, zo, eo);
        checks++; if (zo !== 8'h56 || eo !== 1'b0) begin errors++; $display("FAIL ignore_z got=%h err=%b want 56/0", zo, eo); end
        for (int i = 0; i < 6; i++) begin
            a = $urandom_range(0, 9);
            b = $urandom_range(0, 9);
            run_op(1'b0, 4'(a), 4'(b), 1'b1, 1'b0, lat, zo, eo);
            checks++; if (zo !== ref_z(a, b) || lat !== 11) begin
                errors++; $display("FAIL ignore_rnd %0d*%0d z=%h lat=%0d want %h/11", a, b, zo, lat, ref_z(a, b));
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_exhaustive();
        test_random();
        test_hold();
        test_err_paths();
        test_reset_mid();
        test_ignore_inputs();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog simulation exceeded time budget");
        $fatal(1, "watchdog");
    end

endmodule
